// File: rtl/song_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | song_pkg : note/octave codes, player state encoding and song entry type |
// | GAP state present only when SONG_GAP_EN is defined.                      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package song_pkg;

   localparam int NOTE_CODE_W = 4;
   localparam int DUR_CODE_W  = 4;
   localparam int OCT_CODE_W  = 2;

   localparam logic [NOTE_CODE_W-1:0] NOTE_REST = 4'd0;
   localparam logic [NOTE_CODE_W-1:0] NOTE_T1   = 4'd1;
   localparam logic [NOTE_CODE_W-1:0] NOTE_T2   = 4'd2;
   localparam logic [NOTE_CODE_W-1:0] NOTE_T3   = 4'd3;
   localparam logic [NOTE_CODE_W-1:0] NOTE_T4   = 4'd4;
   localparam logic [NOTE_CODE_W-1:0] NOTE_T5   = 4'd5;
   localparam logic [NOTE_CODE_W-1:0] NOTE_T6   = 4'd6;
   localparam logic [NOTE_CODE_W-1:0] NOTE_T7   = 4'd7;

   // Octave 0 is kept free so that an idle output is distinguishable.
   localparam logic [OCT_CODE_W-1:0] OCT_LO = 2'd1;
   localparam logic [OCT_CODE_W-1:0] OCT_MA = 2'd2;
   localparam logic [OCT_CODE_W-1:0] OCT_HI = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_PLAY  = 3'd2,
`ifdef SONG_GAP_EN
      ST_GAP   = 3'd3,
`endif
      ST_HOLD  = 3'd4
   } state_t;

   typedef struct packed {
      logic [NOTE_CODE_W-1:0] note;
      logic [DUR_CODE_W-1:0]  dur;
      logic [OCT_CODE_W-1:0]  octave;
   } song_entry_t;

   function automatic song_entry_t mk_entry(input logic [NOTE_CODE_W-1:0] n,
                                            input logic [DUR_CODE_W-1:0]  d,
                                            input logic [OCT_CODE_W-1:0]  o);
      song_entry_t e;
      e.note   = n;
      e.dur    = d;
      e.octave = o;
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | song_rom : song library, one registered entry per clock (1-cycle read)  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module song_rom
   import song_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] song_i,
   input  logic [IDX_W-1:0] idx_i,
   output song_entry_t      entry_o
);

   song_entry_t entry_d;
   song_entry_t entry_q;

   // Unlisted songs/indices read as dur==0, i.e. an end marker.
   always_comb begin
      entry_d = '0;
      case (song_i)
         SEL_W'(0): begin
            case (idx_i)
               IDX_W'(0): entry_d = mk_entry(NOTE_T1, 4'd2, OCT_MA);
               IDX_W'(1): entry_d = mk_entry(NOTE_T5, 4'd1, OCT_LO);
               default:   entry_d = '0;
            endcase
         end
         SEL_W'(1): begin
            case (idx_i)
               IDX_W'(0): entry_d = mk_entry(NOTE_T3,   4'd1, OCT_HI);
               IDX_W'(1): entry_d = mk_entry(NOTE_REST, 4'd1, OCT_MA);
               IDX_W'(2): entry_d = mk_entry(NOTE_T7,   4'd3, OCT_LO);
               default:   entry_d = '0;
            endcase
         end
         SEL_W'(2): begin
            case (idx_i)
               IDX_W'(0): entry_d = mk_entry(NOTE_T2, 4'd1, OCT_HI);
               IDX_W'(1): entry_d = mk_entry(NOTE_T3, 4'd1, OCT_HI);
               IDX_W'(2): entry_d = mk_entry(NOTE_T4, 4'd1, OCT_HI);
               IDX_W'(3): entry_d = mk_entry(NOTE_T6, 4'd1, OCT_HI);
               default:   entry_d = '0;
            endcase
         end
         default: entry_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) entry_q <= '0;
      else     entry_q <= entry_d;
   end

   assign entry_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/song_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | song_player : plays {note,dur,octave} entries from song_rom with pause, |
// | stop and done. Define SONG_GAP_EN to insert an auto-rest after notes.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module song_player
   import song_pkg::*;
#(
   parameter int NUM_SONGS      = 8,
   parameter int MAX_NOTES      = 64,
   parameter int NOTE_W         = NOTE_CODE_W,
   parameter int OCT_W          = OCT_CODE_W,
   parameter int DUR_W          = DUR_CODE_W,
   parameter int TICKS_PER_UNIT = 12_500_000
`ifdef SONG_GAP_EN
   ,
   parameter int GAP_TICKS      = 1_250_000
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [$clog2(NUM_SONGS)-1:0] song_sel_i,
   input  logic                         start_i,
   input  logic                         pause_i,
   input  logic                         stop_i,
   output logic [NOTE_W-1:0]            note_o,
   output logic [OCT_W-1:0]             octave_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [$clog2(MAX_NOTES)-1:0] note_idx_o
);

   localparam int SEL_W  = $clog2(NUM_SONGS);
   localparam int IDX_W  = $clog2(MAX_NOTES);
   localparam int PROD_W = DUR_W + $clog2(TICKS_PER_UNIT) + 1;
`ifdef SONG_GAP_EN
   localparam int GAP_W  = $clog2(GAP_TICKS + 1);
   localparam int CNT_W  = (PROD_W > GAP_W) ? PROD_W : GAP_W;
`else
   localparam int CNT_W  = PROD_W;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NOTES - 1);

   state_t             state_q, state_d;
   state_t             ret_q, ret_d;
   logic [SEL_W-1:0]   song_q, song_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NOTE_W-1:0]  note_q, note_d;
   logic [OCT_W-1:0]   oct_q, oct_d;
   logic               done_q, done_d;
`ifdef SONG_GAP_EN
   logic               last_q, last_d;
`endif
   logic               end_song;
   logic               sel_ok;
   song_entry_t        rom_entry;
   logic [PROD_W-1:0]  dur_ticks;

   // ROM is addressed with next-state values so FETCH sees its entry.
   song_rom #(
      .SEL_W (SEL_W),
      .IDX_W (IDX_W)
   ) u_rom (
      .clk     (clk),
      .rst     (rst),
      .song_i  (song_d),
      .idx_i   (idx_d),
      .entry_o (rom_entry)
   );

   assign sel_ok    = int'(song_sel_i) < NUM_SONGS;
   assign dur_ticks = PROD_W'(DUR_W'(rom_entry.dur)) * PROD_W'(TICKS_PER_UNIT);

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      song_d   = song_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      note_d   = note_q;
      oct_d    = oct_q;
      done_d   = 1'b0;
      end_song = 1'b0;
`ifdef SONG_GAP_EN
      last_d   = last_q;
`endif
      if (stop_i && (state_q != ST_IDLE)) begin
         end_song = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  song_d = song_sel_i;
                  idx_d  = '0;
                  if (sel_ok) state_d  = ST_FETCH;
                  else        end_song = 1'b1;
               end
            end
            ST_FETCH: begin
               if (rom_entry.dur == '0) begin
                  end_song = 1'b1;
               end else begin
                  note_d  = NOTE_W'(rom_entry.note);
                  oct_d   = OCT_W'(rom_entry.octave);
                  cnt_d   = CNT_W'(dur_ticks);
                  state_d = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (cnt_q <= CNT_W'(1)) begin
`ifdef SONG_GAP_EN
                  note_d  = '0;
                  cnt_d   = CNT_W'(GAP_TICKS);
                  state_d = ST_GAP;
                  if (idx_q == LAST_IDX) last_d = 1'b1;
                  else                   idx_d  = idx_q + 1'b1;
`else
                  if (idx_q == LAST_IDX) begin
                     end_song = 1'b1;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = ST_FETCH;
                  end
`endif
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  if (pause_i) begin
                     ret_d   = ST_PLAY;
                     state_d = ST_HOLD;
                  end
               end
            end
`ifdef SONG_GAP_EN
            ST_GAP: begin
               if (cnt_q <= CNT_W'(1)) begin
                  if (last_q) end_song = 1'b1;
                  else        state_d  = ST_FETCH;
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  if (pause_i) begin
                     ret_d   = ST_GAP;
                     state_d = ST_HOLD;
                  end
               end
            end
`endif
            ST_HOLD: begin
               if (!pause_i) state_d = ret_q;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (end_song) begin
         state_d = ST_IDLE;
         note_d  = '0;
         oct_d   = '0;
         done_d  = 1'b1;
`ifdef SONG_GAP_EN
         last_d  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ret_q   <= ST_PLAY;
         song_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         note_q  <= '0;
         oct_q   <= '0;
         done_q  <= 1'b0;
`ifdef SONG_GAP_EN
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         song_q  <= song_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         note_q  <= note_d;
         oct_q   <= oct_d;
         done_q  <= done_d;
`ifdef SONG_GAP_EN
         last_q  <= last_d;
`endif
      end
   end

   assign note_o     = note_q;
   assign octave_o   = oct_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = done_q;
   assign note_idx_o = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_song_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_song_player : per-cycle vector tables through a scoreboard queue     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_song_player;
   import song_pkg::*;

   localparam int NS  = 5;
   localparam int MN  = 4;
   localparam int TPU = 4;
`ifdef SONG_GAP_EN
   localparam int GT  = 2;
`endif
   localparam int SW  = $clog2(NS);
   localparam int IW  = $clog2(MN);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [SW-1:0] song_sel_i = '0;
   logic          start_i = 1'b0;
   logic          pause_i = 1'b0;
   logic          stop_i  = 1'b0;
   logic [3:0]    note_o;
   logic [1:0]    octave_o;
   logic          busy_o;
   logic          done_o;
   logic [IW-1:0] note_idx_o;

   always #5 clk = ~clk;

   song_player #(
      .NUM_SONGS      (NS),
      .MAX_NOTES      (MN),
      .TICKS_PER_UNIT (TPU)
`ifdef SONG_GAP_EN
      ,
      .GAP_TICKS      (GT)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .song_sel_i (song_sel_i),
      .start_i    (start_i),
      .pause_i    (pause_i),
      .stop_i     (stop_i),
      .note_o     (note_o),
      .octave_o   (octave_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .note_idx_o (note_idx_o)
   );

   typedef struct {
      bit            st;
      bit            pa;
      bit            sp;
      logic [SW-1:0] sel;
      logic [3:0]    nt;
      logic [1:0]    oc;
      logic          bz;
      logic          dn;
      logic [IW-1:0] ix;
   } vec_t;

   vec_t vq[$];
   vec_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // n consecutive cycles: inputs driven in the cycle, outputs seen in it.
   function automatic void r(input int n, input bit st, input bit pa, input bit sp,
                             input int sel, input int nt, input int oc,
                             input bit bz, input bit dn, input int ix);
      vec_t v;
      v.st = st; v.pa = pa; v.sp = sp;
      v.sel = SW'(sel); v.nt = 4'(nt); v.oc = 2'(oc);
      v.bz = bz; v.dn = dn; v.ix = IW'(ix);
      for (int k = 0; k < n; k++) vq.push_back(v);
   endfunction

   task automatic check(input string nm, input int c);
      vec_t e;
      e = sb.pop_front();
      total++;
      if (note_o !== e.nt || octave_o !== e.oc || busy_o !== e.bz ||
          done_o !== e.dn || note_idx_o !== e.ix) begin
         bad++;
         $display("FAIL %s cycle %0d: got note=%0d oct=%0d busy=%0b done=%0b idx=%0d, want note=%0d oct=%0d busy=%0b done=%0b idx=%0d",
                  nm, c, note_o, octave_o, busy_o, done_o, note_idx_o,
                  e.nt, e.oc, e.bz, e.dn, e.ix);
      end
   endtask

   task automatic chk_zero(input string nm);
      total++;
      if (note_o !== 4'd0 || octave_o !== 2'd0 || busy_o !== 1'b0 ||
          done_o !== 1'b0 || note_idx_o !== '0) begin
         bad++;
         $display("FAIL %s: got note=%0d oct=%0d busy=%0b done=%0b idx=%0d, want all 0",
                  nm, note_o, octave_o, busy_o, done_o, note_idx_o);
      end
   endtask

   task automatic play(input string nm);
      for (int i = 0; i < vq.size(); i++) begin
         start_i    = vq[i].st;
         pause_i    = vq[i].pa;
         stop_i     = vq[i].sp;
         song_sel_i = vq[i].sel;
         sb.push_back(vq[i]);
         check(nm, i);
         @(posedge clk);
         @(negedge clk);
      end
      vq.delete();
      start_i = 1'b0; pause_i = 1'b0; stop_i = 1'b0; song_sel_i = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wn[4];
      wn[0] = NOTE_T2; wn[1] = NOTE_T3; wn[2] = NOTE_T4; wn[3] = NOTE_T6;

      #12;
      chk_zero("reset_state");
      @(negedge clk);
      rst = 1'b0;

      // Song 0; start held and song_sel changed while busy must be ignored.
      r(1, 1,0,0, 0, 0,0,0,0,0);
      r(1, 1,0,0, 0, 0,0,1,0,0);
      r(4, 1,0,0, 1, NOTE_T1,OCT_MA,1,0,0);
      r(4, 0,0,0, 0, NOTE_T1,OCT_MA,1,0,0);
`ifdef SONG_GAP_EN
      r(3, 0,0,0, 0, 0,OCT_MA,1,0,1);
      r(4, 0,0,0, 0, NOTE_T5,OCT_LO,1,0,1);
      r(3, 0,0,0, 0, 0,OCT_LO,1,0,2);
`else
      r(1, 0,0,0, 0, NOTE_T1,OCT_MA,1,0,1);
      r(4, 0,0,0, 0, NOTE_T5,OCT_LO,1,0,1);
      r(1, 0,0,0, 0, NOTE_T5,OCT_LO,1,0,2);
`endif
      r(1, 0,0,0, 0, 0,0,0,1,2);
      r(2, 0,0,0, 0, 0,0,0,0,2);
      play("song0");

      // Pause for 5 cycles from cycle 4, then stop at cycle 15.
      do_reset();
      r(1, 1,0,0, 0, 0,0,0,0,0);
      r(1, 0,0,0, 0, 0,0,1,0,0);
      r(2, 0,0,0, 0, NOTE_T1,OCT_MA,1,0,0);
      r(5, 0,1,0, 0, NOTE_T1,OCT_MA,1,0,0);
      r(6, 0,0,0, 0, NOTE_T1,OCT_MA,1,0,0);
`ifdef SONG_GAP_EN
      r(1, 0,0,1, 0, 0,OCT_MA,1,0,1);
`else
      r(1, 0,0,1, 0, NOTE_T1,OCT_MA,1,0,1);
`endif
      r(1, 0,0,0, 0, 0,0,0,1,1);
      r(1, 0,0,0, 0, 0,0,0,0,1);
      play("pause");

      // Stop and pause together at cycle 6.
      do_reset();
      r(1, 1,0,0, 0, 0,0,0,0,0);
      r(1, 0,0,0, 0, 0,0,1,0,0);
      r(4, 0,0,0, 0, NOTE_T1,OCT_MA,1,0,0);
      r(1, 0,1,1, 0, NOTE_T1,OCT_MA,1,0,0);
      r(1, 0,0,0, 0, 0,0,0,1,0);
      r(2, 0,0,0, 0, 0,0,0,0,0);
      play("stop_pause");

      // song_sel == NUM_SONGS: done in the cycle after start, no notes.
      r(1, 1,0,0, NS, 0,0,0,0,0);
      r(1, 0,0,0, 0, 0,0,0,1,0);
      r(2, 0,0,0, 0, 0,0,0,0,0);
      play("bad_sel");

      // Song 2 fills all MAX_NOTES entries: ends by index wrap.
      do_reset();
      r(1, 1,0,0, 2, 0,0,0,0,0);
      r(1, 0,0,0, 2, 0,0,1,0,0);
      for (int k = 0; k < 4; k++) begin
         r(4, 0,0,0, 0, wn[k],OCT_HI,1,0,k);
`ifdef SONG_GAP_EN
         r(2, 0,0,0, 0, 0,OCT_HI,1,0,(k < 3) ? k + 1 : 3);
         if (k < 3) r(1, 0,0,0, 0, 0,OCT_HI,1,0,k + 1);
`else
         if (k < 3) r(1, 0,0,0, 0, wn[k],OCT_HI,1,0,k + 1);
`endif
      end
      r(1, 0,0,0, 0, 0,0,0,1,3);
      r(1, 0,0,0, 0, 0,0,0,0,3);
      play("wrap");

      // Asynchronous reset in the middle of the first note.
      do_reset();
      r(1, 1,0,0, 0, 0,0,0,0,0);
      r(1, 0,0,0, 0, 0,0,1,0,0);
      r(4, 0,0,0, 0, NOTE_T1,OCT_MA,1,0,0);
      play("pre_rst");
      #1 rst = 1'b1;
      #1 chk_zero("rst_async");
      @(posedge clk);
      #1 chk_zero("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      r(1, 1,0,0, 0, 0,0,0,0,0);
      r(1, 0,0,0, 0, 0,0,1,0,0);
      r(8, 0,0,0, 0, NOTE_T1,OCT_MA,1,0,0);
`ifdef SONG_GAP_EN
      r(1, 0,0,1, 0, 0,OCT_MA,1,0,1);
`else
      r(1, 0,0,1, 0, NOTE_T1,OCT_MA,1,0,1);
`endif
      r(1, 0,0,0, 0, 0,0,0,1,1);
      r(1, 0,0,0, 0, 0,0,0,0,1);
      play("replay");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 Parameter NUM_SONGS, default 8: number of songs held in the library.
REQ-002 Parameter MAX_NOTES, default 64: maximum entries per song.
REQ-003 Parameter NOTE_W, default 4: note code width; code 0 = rest.
REQ-004 Parameter OCT_W, default 2: octave code width (lo/ma/hi).
REQ-005 Parameter DUR_W, default 4: duration width, in units.
REQ-006 Parameter TICKS_PER_UNIT, default 12_500_000: clk cycles per duration unit.
REQ-007 Parameter GAP_TICKS, default 1_250_000: auto-rest length in cycles.
REQ-008 clk  in  1  system clock, rising edge.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 song_sel  in  $clog2(NUM_SONGS)  song number, sampled on accepted start.
REQ-011 start  in  1  level; begin playback when IDLE.
REQ-012 pause  in  1  level; freeze playback while high.
REQ-013 stop  in  1  abort playback.
REQ-014 note  out  NOTE_W  current note code.
REQ-015 octave  out  OCT_W  current octave code.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse at song end or abort.
REQ-018 note_idx  out  $clog2(MAX_NOTES)  index of the entry being played.

Function
REQ-019 The block SHALL use the FSM states IDLE, FETCH, PLAY, GAP and HOLD.
REQ-020 Song entries SHALL be {note, dur, octave}; an entry with dur==0 SHALL mark end of song.
REQ-021 In IDLE, start=1 SHALL latch song_sel, clear note_idx and go to FETCH; start SHALL be ignored in any other state.
REQ-022 FETCH SHALL last exactly 1 cycle (registered ROM read); note/octave SHALL hold previous values, or 0 for the first entry.
REQ-023 FETCH SHALL go to PLAY on dur!=0, loading note/octave and a down-counter of dur*TICKS_PER_UNIT cycles; start at cycle 0 gives the first note at cycle 2.
REQ-024 On counter expiry, PLAY SHALL increment note_idx and go to FETCH, or to GAP when SONG_GAP_EN is defined.
REQ-025 End marker, or note_idx wrap past MAX_NOTES-1, SHALL pulse done and go to IDLE with note=0 and octave=0.
REQ-026 song_sel>=NUM_SONGS SHALL produce no notes and pulse done in the cycle after start.
REQ-027 pause=1 in PLAY or GAP SHALL go to HOLD; HOLD SHALL freeze the counter and outputs.
REQ-028 pause=0 in HOLD SHALL resume the state it came from, with the remaining count.
REQ-029 stop SHALL take priority over pause and start in the same cycle: from any non-IDLE state go to IDLE, pulse done and zero note/octave.
REQ-030 The duration product SHALL be computed at a width of DUR_W+$clog2(TICKS_PER_UNIT)+1 with no truncation.

Reset
REQ-031 rst SHALL force IDLE asynchronously with note=0, octave=0, busy=0, done=0, note_idx=0 and counters 0, including mid-song.
REQ-032 After rst deasserts, the block SHALL accept start on the first clock edge.

Configuration
REQ-033 When SONG_GAP_EN is defined, every note SHALL be followed by GAP: note=0, octave held, for GAP_TICKS cycles, then FETCH.
REQ-034 When SONG_GAP_EN is undefined, GAP and GAP_TICKS SHALL be absent and PLAY SHALL go directly to FETCH.

Structure
REQ-035 Package song_pkg SHALL hold the note codes (rest, t1..t7), the octave codes (lo, ma, hi), the state enum and the entry struct typedef.
REQ-036 Song data SHALL live in sub-module song_rom: inputs song index and note index, registered entry output, 1-cycle latency.

Verification (TICKS_PER_UNIT=4, GAP_TICKS=2)
REQ-037 Song 0 = {t1,2,ma},{t5,1,lo},end; start at cycle 0 -> t1/ma on cycles 2-9, t5/lo on cycles 11-14, done at cycle 16.
REQ-038 With SONG_GAP_EN defined, same song -> note=0 for 2 cycles after each note; done at cycle 20.
REQ-039 pause high for 5 cycles at cycle 4 -> t1 extends to cycle 14; note_idx unchanged while paused.
REQ-040 stop and pause both high at cycle 6 -> done at cycle 7, busy=0, note=0.
REQ-041 rst asserted at cycle 5 mid-note -> all outputs 0 immediately, no done pulse; the next start replays from index 0.
REQ-042 song_sel=NUM_SONGS -> done pulse in the cycle after start, note stays 0; start while busy -> ignored.
